// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: widths, EX/MEM control bundle,
// writeback-select encodings and the EX/MEM payload struct.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    ex_mem_ctrl_t      ctrl;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register: load enable, synchronous active-low clear.
// Ports: clk, rst_n (clear), load, d -> q.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_buffer.sv
// EX->MEM 2-entry skid buffer with flush; s_ready is registered.
// Ports: s_* from EX (valid/ready + payload), m_* to MEM, i_flush.
module ex_mem_skid_buffer #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [XLEN-1:0]   s_alu_result,
  input  logic [XLEN-1:0]   s_rs2_data,
  input  logic [XLEN-1:0]   s_pc,
  input  logic [REG_AW-1:0] s_rd,
  input  logic [CTRL_W-1:0] s_ctrl,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [XLEN-1:0]   m_alu_result,
  output logic [XLEN-1:0]   m_rs2_data,
  output logic [XLEN-1:0]   m_pc,
  output logic [REG_AW-1:0] m_rd,
  output logic [CTRL_W-1:0] m_ctrl
);

  localparam int PW = 3 * XLEN + REG_AW + CTRL_W;

  logic          main_v;
  logic          skid_v;
  logic          in_hs;
  logic          out_hs;
  logic          main_ld;
  logic          skid_ld;
  logic          clr_n;
  logic [PW-1:0] s_pay;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign s_pay = {s_alu_result, s_rs2_data, s_pc, s_rd, s_ctrl};

  // Flush wipes the data too, so killed entries never reach m_*.
  assign clr_n = i_rst_n & ~i_flush;

  always_comb begin
    in_hs   = s_valid & ~skid_v;
    out_hs  = main_v & m_ready;
    // in_hs implies ~skid_v, so the two main sources never collide
    main_ld = ~i_flush & ((in_hs & (~main_v | out_hs)) |
                          (skid_v & out_hs));
    skid_ld = ~i_flush & in_hs & main_v & ~out_hs;
    main_d  = skid_v ? skid_q : s_pay;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_v <= main_v ? (~out_hs | in_hs | skid_v) : in_hs;
      skid_v <= skid_v ? ~out_hs
                       : (in_hs & main_v & ~out_hs);
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk   (i_clk),
    .rst_n (clr_n),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk   (i_clk),
    .rst_n (clr_n),
    .load  (skid_ld),
    .d     (s_pay),
    .q     (skid_q)
  );

  assign s_ready = ~skid_v;
  assign m_valid = main_v;
  assign {m_alu_result, m_rs2_data, m_pc, m_rd, m_ctrl} = main_q;

  a_no_orphan_skid: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) (main_v || !skid_v)
  );

endmodule

// File: tb/tb_ex_mem_skid_buffer.sv
// Self-checking bench for ex_mem_skid_buffer: vector table,
// streaming, flush, mid-run reset and random scoreboard.
module tb_ex_mem_skid_buffer;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [XLEN-1:0]   s_alu_result;
  logic [XLEN-1:0]   s_rs2_data;
  logic [XLEN-1:0]   s_pc;
  logic [REG_AW-1:0] s_rd;
  logic [CTRL_W-1:0] s_ctrl;
  logic              m_valid;
  logic              m_ready;
  logic [XLEN-1:0]   m_alu_result;
  logic [XLEN-1:0]   m_rs2_data;
  logic [XLEN-1:0]   m_pc;
  logic [REG_AW-1:0] m_rd;
  logic [CTRL_W-1:0] m_ctrl;

  localparam int PW = 3 * XLEN + REG_AW + CTRL_W;

  always #5 clk = ~clk;

  ex_mem_skid_buffer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_alu_result (s_alu_result),
    .s_rs2_data   (s_rs2_data),
    .s_pc         (s_pc),
    .s_rd         (s_rd),
    .s_ctrl       (s_ctrl),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_alu_result (m_alu_result),
    .m_rs2_data   (m_rs2_data),
    .m_pc         (m_pc),
    .m_rd         (m_rd),
    .m_ctrl       (m_ctrl)
  );

  typedef struct {
    logic        sv;
    logic        mr;
    logic        fl;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        emv;
    logic        esr;
    logic [31:0] ealu;
    logic [4:0]  erd;
  } vec_t;

  vec_t tbl[17];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [PW-1:0] m_pay();
    return {m_alu_result, m_rs2_data, m_pc, m_rd, m_ctrl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic        sv,
                        input logic        mr,
                        input logic        fl,
                        input logic [31:0] alu,
                        input logic [4:0]  rd);
    ex_mem_ctrl_t c;
    c = '{regwrite: 1'b1, memread: 1'b0, memwrite: 1'b0,
          wb_sel: WB_ALU, funct3: 3'b101};
    s_valid      = sv;
    m_ready      = mr;
    flush        = fl;
    s_alu_result = alu;
    s_rs2_data   = ~alu;
    s_pc         = {alu[29:0], 2'b00};
    s_rd         = rd;
    s_ctrl       = c;
  endtask

  function automatic vec_t v(input logic sv, input logic mr,
                             input logic fl, input logic [31:0] alu,
                             input logic [4:0] rd,
                             input logic emv, input logic esr,
                             input logic [31:0] ealu,
                             input logic [4:0] erd);
    vec_t r;
    r = '{sv, mr, fl, alu, rd, emv, esr, ealu, erd};
    return r;
  endfunction

  logic [PW-1:0] q[$];
  logic [PW-1:0] held;
  logic [PW-1:0] rnd;
  logic [PW-1:0] exp_p;
  logic          hold_chk;
  ex_mem_ctrl_t  mc;

  initial begin
    // single pass
    tbl[0]  = v(1,1,0,32'hFFFF_FFF0,5,  1,1,32'hFFFF_FFF0,5);
    tbl[1]  = v(0,1,0,32'h0,        0,  0,1,32'hFFFF_FFF0,5);
    // backpressure fill and drain
    tbl[2]  = v(1,0,0,32'h11,       1,  1,1,32'h11,1);
    tbl[3]  = v(1,0,0,32'h22,       2,  1,0,32'h11,1);
    tbl[4]  = v(1,0,0,32'h33,       3,  1,0,32'h11,1);
    tbl[5]  = v(0,1,0,32'h0,        0,  1,1,32'h22,2);
    tbl[6]  = v(0,1,0,32'h0,        0,  0,1,32'h22,2);
    // flush when full
    tbl[7]  = v(1,0,0,32'hAA,      10,  1,1,32'hAA,10);
    tbl[8]  = v(1,0,0,32'hBB,      11,  1,0,32'hAA,10);
    tbl[9]  = v(1,0,1,32'hCC,      12,  0,1,32'h0,0);
    tbl[10] = v(0,1,0,32'h0,        0,  0,1,32'h0,0);
    // flush coincident with an out-handshake
    tbl[11] = v(1,0,0,32'hDD,      13,  1,1,32'hDD,13);
    tbl[12] = v(1,1,1,32'hEE,      14,  0,1,32'h0,0);
    // ONE + in + out keeps one entry
    tbl[13] = v(1,1,0,32'h01,       1,  1,1,32'h01,1);
    tbl[14] = v(1,1,0,32'h02,       2,  1,1,32'h02,2);
    tbl[15] = v(0,0,0,32'h0,        0,  1,1,32'h02,2);
    tbl[16] = v(0,1,0,32'h0,        0,  0,1,32'h02,2);

    rst_n = 1'b0;
    set_in(0, 0, 0, 32'h0, 5'd0);
    tick();
    tick();
    chk("rst_m_valid", 128'(m_valid), 128'(1'b0));
    chk("rst_s_ready", 128'(s_ready), 128'(1'b1));
    chk("rst_alu", 128'(m_alu_result), 128'(32'h0));
    chk("rst_pay", 128'(m_pay()), 128'({PW{1'b0}}));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].sv, tbl[i].mr, tbl[i].fl,
             tbl[i].alu, tbl[i].rd);
      tick();
      chk($sformatf("vec%0d_m_valid", i),
          128'(m_valid), 128'(tbl[i].emv));
      chk($sformatf("vec%0d_s_ready", i),
          128'(s_ready), 128'(tbl[i].esr));
      chk($sformatf("vec%0d_alu", i),
          128'(m_alu_result), 128'(tbl[i].ealu));
      chk($sformatf("vec%0d_rd", i),
          128'(m_rd), 128'(tbl[i].erd));
      if (i == 0) begin
        mc = m_ctrl;
        chk("vec0_regwrite", 128'(mc.regwrite), 128'(1'b1));
        chk("vec0_rs2", 128'(m_rs2_data), 128'(32'h0000_000F));
      end
    end

    // streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++) begin
      set_in(1, 1, 0, 32'(k), 5'(k));
      tick();
      chk($sformatf("stream%0d_valid", k),
          128'(m_valid), 128'(1'b1));
      chk($sformatf("stream%0d_alu", k),
          128'(m_alu_result), 128'(k));
      chk($sformatf("stream%0d_ready", k),
          128'(s_ready), 128'(1'b1));
    end
    set_in(0, 1, 0, 32'h0, 5'd0);
    tick();
    chk("stream_drain", 128'(m_valid), 128'(1'b0));

    // random valid/ready with scoreboard
    hold_chk = 1'b0;
    held     = '0;
    for (int c = 0; c < 12000; c++) begin
      chk("rnd_m_valid", 128'(m_valid), 128'(q.size() > 0));
      chk("rnd_s_ready", 128'(s_ready), 128'(q.size() < 2));
      if (hold_chk)
        chk("rnd_hold", 128'(m_pay()), 128'(held));
      rnd = {$urandom, $urandom, $urandom,
             5'($urandom), 8'($urandom)};
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = 1'b0;
      {s_alu_result, s_rs2_data, s_pc, s_rd, s_ctrl} = rnd;
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 128'(1'b1), 128'(1'b0));
        end else begin
          exp_p = q.pop_front();
          chk("rnd_order", 128'(m_pay()), 128'(exp_p));
        end
      end
      if (s_valid && s_ready)
        q.push_back(rnd);
      hold_chk = m_valid & ~m_ready;
      held     = m_pay();
      tick();
    end

    // reset mid-operation discards everything
    set_in(1, 0, 0, 32'h5555, 5'd7);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_m_valid", 128'(m_valid), 128'(1'b0));
    chk("midrst_s_ready", 128'(s_ready), 128'(1'b1));
    chk("midrst_pay", 128'(m_pay()), 128'({PW{1'b0}}));
    rst_n = 1'b1;
    set_in(0, 1, 0, 32'h0, 5'd0);
    tick();
    chk("midrst_after", 128'(m_valid), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
